// File: rtl/ibex_arb_pkg.sv
// ibex_arb_pkg: shared state type and sizing helper for the Ibex memory arbiter
package ibex_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;
  function automatic int own_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ibex_mem_arbiter_if.sv
// ibex_mem_arbiter_if: per-requester vectors plus the shared downstream memory port
interface ibex_mem_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N_REQ-1:0] req_i, gnt_o, rvalid_o, we_i, err_o;
  logic [N_REQ-1:0][DW/8-1:0] be_i;
  logic [N_REQ-1:0][AW-1:0] addr_i;
  logic [N_REQ-1:0][DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o, m_wdata_o, m_rdata_i;
  logic m_req_o, m_gnt_i, m_rvalid_i, m_we_o, m_err_i;
  logic [DW/8-1:0] m_be_o;
  logic [AW-1:0] m_addr_o;
  modport slave (
    input req_i, we_i, be_i, addr_i, wdata_i, m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
    output gnt_o, rvalid_o, err_o, rdata_o, m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
    input gnt_o, rvalid_o, err_o, rdata_o, m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search from ptr, as a double-width masked priority encoder
module rr_pick import ibex_arb_pkg::*; #(
  parameter int N = 2,
  localparam int W = own_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [2*N-1:0] dbl;
  assign dbl = {req, req};
  assign valid = |req;
  // descending scan so the lowest unmasked bit at or above ptr wins
  always_comb begin
    idx = '0;
    for (int i = 2*N-1; i >= 0; i--) idx = (dbl[i] && i >= int'(ptr)) ? W'(i % N) : idx;
  end
endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: N-to-1 round-robin arbiter, one outstanding transaction,
// ownership held from selection until the downstream rvalid
module ibex_mem_arbiter import ibex_arb_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk_i,
  input logic rst_i,
  ibex_mem_arbiter_if.slave bus
);
  localparam int OWN_W = own_w(N_REQ);
  arb_state_e state, state_nxt;
  logic [OWN_W-1:0] owner, rr_ptr, win;
  logic win_valid, done, in_req;
  logic [DW-1:0] rdata_q;
  logic [N_REQ-1:0] own_oh;
  rr_pick #(.N(N_REQ)) u_pick (.req(bus.req_i), .ptr(rr_ptr), .idx(win), .valid(win_valid));
  assign in_req = state == REQ;
  assign own_oh = N_REQ'(1) << owner;
  assign done = bus.m_rvalid_i && (state == RESP || (in_req && bus.m_gnt_i));
  always_comb begin
    state_nxt = (state == IDLE) ? (win_valid ? REQ : IDLE) :
                done ? IDLE :
                in_req ? (bus.m_gnt_i ? RESP : REQ) :
                (state == RESP) ? RESP : IDLE;
  end
  assign bus.m_req_o = in_req;
  assign bus.m_we_o = in_req && bus.we_i[owner];
  assign bus.m_be_o = in_req ? bus.be_i[owner] : '0;
  assign bus.m_addr_o = in_req ? bus.addr_i[owner] : AW'(0);
  assign bus.m_wdata_o = in_req ? bus.wdata_i[owner] : DW'(0);
  assign bus.gnt_o = (in_req && bus.m_gnt_i) ? own_oh : '0;
  assign bus.rvalid_o = done ? own_oh : '0;
  assign bus.err_o = (done && bus.m_err_i) ? own_oh : '0;
  assign bus.rdata_o = done ? bus.m_rdata_i : rdata_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_valid) owner <= win;
      if (done) begin
        rr_ptr <= (int'(owner) == N_REQ-1) ? '0 : owner + 1'b1;
        rdata_q <= bus.m_rdata_i;
      end
    end
  end
  // the owner must hold its request until granted; m_req_o stays up regardless
  always_ff @(posedge clk_i)
    if (!rst_i && in_req) assert (bus.req_i[owner]) else $error("owner dropped req_i while in REQ");
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_ibex_mem_arbiter;
  localparam int N = 2, AW = 32, DW = 32;
  logic clk = 0, rst = 1;
  ibex_mem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();
  ibex_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    bus.m_gnt_i = 0;
    bus.m_rvalid_i = 0;
    bus.m_err_i = 0;
  endtask
  // model: who holds the port, whether downstream accepted, next search start, last read data
  int cur = -1, ptr = 0, ndone = 0;
  int waitc [N];
  bit acc = 0, live = 0;
  logic [DW-1:0] rd_hold = '0;
  always @(negedge clk) begin
    bit done, emreq;
    int ci;
    logic [N-1:0] oh;
    ci = (cur < 0) ? 0 : cur;
    oh = (cur >= 0) ? N'(1) << cur : '0;
    emreq = cur >= 0 && !acc;
    done = cur >= 0 && bus.m_rvalid_i && (acc || bus.m_gnt_i);
    if (live) begin
      chk("m_req", 64'(bus.m_req_o), 64'(emreq));
      chk("m_we", 64'(bus.m_we_o), 64'(emreq && bus.we_i[ci]));
      chk("m_be", 64'(bus.m_be_o), emreq ? 64'(bus.be_i[ci]) : 64'(0));
      chk("m_addr", 64'(bus.m_addr_o), emreq ? 64'(bus.addr_i[ci]) : 64'(0));
      chk("m_wdata", 64'(bus.m_wdata_o), emreq ? 64'(bus.wdata_i[ci]) : 64'(0));
      chk("gnt", 64'(bus.gnt_o), (emreq && bus.m_gnt_i) ? 64'(oh) : 64'(0));
      chk("rvalid", 64'(bus.rvalid_o), done ? 64'(oh) : 64'(0));
      chk("err", 64'(bus.err_o), (done && bus.m_err_i) ? 64'(oh) : 64'(0));
      chk("rdata", 64'(bus.rdata_o), done ? 64'(bus.m_rdata_i) : 64'(rd_hold));
    end
    if (rst) begin
      live = 1;
      cur = -1;
      acc = 0;
      ptr = 0;
      rd_hold = '0;
      waitc = '{default: 0};
    end else if (live) begin
      if (cur < 0) begin
        for (int k = N-1; k >= 0; k--) if (bus.req_i[(ptr+k)%N]) cur = (ptr+k)%N;
        if (cur >= 0) begin
          acc = 0;
          waitc[cur] = 0;
        end
      end else if (done) begin
        for (int i = 0; i < N; i++)
          if (i != cur && bus.req_i[i]) begin
            waitc[i]++;
            chk("fair_wait_exceeded", 64'(waitc[i] > N-1), 64'(0));
          end
        ptr = (cur + 1) % N;
        rd_hold = bus.m_rdata_i;
        ndone++;
        cur = -1;
      end else if (emreq && bus.m_gnt_i) acc = 1;
    end
  end
  initial begin
    int gwait, rwait, cycles, base;
    bit await;
    logic [N-1:0] seen;
    bus.req_i = '0; bus.we_i = '0; bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.m_gnt_i = 0; bus.m_rvalid_i = 0; bus.m_rdata_i = '0; bus.m_err_i = 0;
    repeat (2) cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_m_req", 64'(bus.m_req_o), 64'(0));
    chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
    chk("rst_rdata", 64'(bus.rdata_o), 64'(0));
    // single read from requester 0, downstream grant on the third REQ cycle
    cyc(); bus.req_i = 2'b01; bus.addr_i[0] = 32'h100; bus.be_i[0] = 4'hF;
    @(negedge clk); chk("sr_idle_m_req", 64'(bus.m_req_o), 64'(0));
    cyc();
    @(negedge clk); chk("sr_m_req", 64'(bus.m_req_o), 64'(1)); chk("sr_addr", 64'(bus.m_addr_o), 64'h100);
    cyc();
    cyc(); bus.m_gnt_i = 1;
    @(negedge clk); chk("sr_gnt", 64'(bus.gnt_o), 64'b01);
    cyc(); bus.req_i = '0; bus.m_gnt_i = 0; bus.m_rvalid_i = 1; bus.m_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("sr_rvalid", 64'(bus.rvalid_o), 64'b01);
    chk("sr_rdata", 64'(bus.rdata_o), 64'hDEADBEEF);
    cyc(); bus.m_rvalid_i = 0; bus.m_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("sr_rvalid_off", 64'(bus.rvalid_o), 64'(0));
    chk("sr_rdata_hold", 64'(bus.rdata_o), 64'hDEADBEEF);
    // same-cycle gnt and rvalid on a write from requester 1
    cyc(); bus.req_i = 2'b10; bus.we_i = 2'b10; bus.wdata_i[1] = 32'hB; bus.addr_i[1] = 32'h200;
    cyc(); bus.m_gnt_i = 1; bus.m_rvalid_i = 1;
    @(negedge clk);
    chk("sc_wdata", 64'(bus.m_wdata_o), 64'hB);
    chk("sc_gnt", 64'(bus.gnt_o), 64'b10);
    chk("sc_rvalid", 64'(bus.rvalid_o), 64'b10);
    cyc(); idle_in(); bus.req_i = 2'b11; bus.we_i = 2'b11; bus.wdata_i[0] = 32'hA;
    @(negedge clk); chk("sc_idle", 64'(bus.m_req_o), 64'(0));
    // contention: both held, grants must alternate starting at 0
    for (int t = 0; t < 6; t++) begin
      cyc(); bus.m_gnt_i = 1;
      @(negedge clk);
      chk("ct_gnt", 64'(bus.gnt_o), (t % 2) ? 64'b10 : 64'b01);
      chk("ct_wdata", 64'(bus.m_wdata_o), (t % 2) ? 64'hB : 64'hA);
      cyc(); bus.m_gnt_i = 0; bus.m_rvalid_i = 1;
      cyc(); bus.m_rvalid_i = 0;
    end
    // error response on a read from requester 0
    bus.req_i = 2'b01; bus.we_i = '0; bus.addr_i[0] = 32'h300;
    cyc(); bus.m_gnt_i = 1;
    cyc(); bus.req_i = '0; bus.m_gnt_i = 0; bus.m_rvalid_i = 1; bus.m_err_i = 1;
    @(negedge clk); chk("er_err", 64'(bus.err_o), 64'b01);
    cyc(); idle_in();
    @(negedge clk); chk("er_err_off", 64'(bus.err_o), 64'(0));
    // reset while waiting for the response, then a late rvalid
    bus.req_i = 2'b01;
    cyc(); bus.m_gnt_i = 1;
    cyc(); bus.req_i = '0; bus.m_gnt_i = 0; rst = 1;
    cyc(); rst = 0; bus.m_rvalid_i = 1; bus.m_rdata_i = 32'hCAFE;
    @(negedge clk);
    chk("rr_rvalid", 64'(bus.rvalid_o), 64'(0));
    chk("rr_m_req", 64'(bus.m_req_o), 64'(0));
    chk("rr_rdata", 64'(bus.rdata_o), 64'(0));
    cyc(); bus.m_rvalid_i = 0; bus.req_i = 2'b10; bus.addr_i[1] = 32'h400;
    cyc(); bus.m_gnt_i = 1; bus.m_rvalid_i = 1;
    @(negedge clk);
    chk("rr_gnt1", 64'(bus.gnt_o), 64'b10);
    chk("rr_rvalid1", 64'(bus.rvalid_o), 64'b10);
    cyc(); idle_in(); bus.req_i = '0;
    // randomized traffic with downstream latency 0..5
    base = ndone; cycles = 0; await = 0; seen = '0; rwait = 0;
    gwait = $urandom_range(0, 5);
    while (ndone - base < 1000 && cycles < 30000) begin
      cyc();
      cycles++;
      for (int i = 0; i < N; i++)
        if (bus.req_i[i] && seen[i]) bus.req_i[i] = 0;
        else if (!bus.req_i[i] && $urandom_range(0, 2) == 0) begin
          bus.req_i[i] = 1;
          bus.we_i[i] = 1'($urandom);
          bus.be_i[i] = 4'($urandom);
          bus.addr_i[i] = $urandom;
          bus.wdata_i[i] = $urandom;
        end
      idle_in();
      bus.m_err_i = $urandom_range(0, 7) == 0;
      bus.m_rdata_i = $urandom;
      if (bus.m_req_o) begin
        if (gwait > 0) gwait--;
        else begin
          bus.m_gnt_i = 1;
          gwait = $urandom_range(0, 5);
          rwait = $urandom_range(0, 5);
          if (rwait == 0) bus.m_rvalid_i = 1;
          else await = 1;
        end
      end else if (await) begin
        rwait--;
        if (rwait == 0) begin
          bus.m_rvalid_i = 1;
          await = 0;
        end
      end
      @(negedge clk);
      seen = bus.gnt_o;
    end
    chk("rand_completed", 64'(ndone - base), 64'(1000));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
